// File: rtl/alu_console.sv
// Operand/opcode latch and multi-cycle ALU launcher with a circular result history mapped onto LCD display slots.
// Entries act on the edge they arrive and are dropped while busy; display outputs lag display_number by one cycle.
module alu_console #(
  parameter int WIDTH      = 32,
  parameter int OPW        = 4,
  parameter int HIST_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             input_valid,
  input  logic [31:0]      input_value,
  input  logic [2:0]       input_sel,
  output logic [OPW-1:0]   alu_op,
  output logic [OPW-1:0]   alu_op1,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  input  logic [5:0]       display_number,
  output logic             display_valid,
  output logic [39:0]      display_name,
  output logic [31:0]      display_value,
  output logic             busy,
  output logic             timeout
);
  localparam int PW = $clog2(HIST_DEPTH);
  localparam int CW = $clog2(HIST_DEPTH + 1);
  localparam logic [15:0]   WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL      = CW'(HIST_DEPTH);
  localparam logic [5:0]    H_FIRST   = 6'd9;
  localparam logic [5:0]    H_END     = 6'(9 + HIST_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] cap_result, last_result;
  logic [3:0]       cap_flags, last_flags;
  logic [WIDTH+3:0] hist [HIST_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      wait_cnt;
  logic             entry, wait_expired;

  // Entries only land in IDLE, which keeps operands frozen for the whole operation.
  assign entry        = input_valid && (state == IDLE);
  assign wait_expired = (state == WAIT) && !alu_done && (wait_cnt == WAIT_LAST);
  assign alu_start    = (state == ISSUE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (entry && input_sel == 3'b100) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (alu_done)          state_nxt = COMMIT;
        else if (wait_expired) state_nxt = IDLE;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_op      <= '0;
      alu_op1     <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      timeout     <= 1'b0;
      wait_cnt    <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      cap_result  <= '0;
      cap_flags   <= '0;
      last_result <= '0;
      last_flags  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      if (entry) begin
        case (input_sel)
          3'b000: alu_op   <= input_value[OPW-1:0];
          3'b001: alu_op1  <= input_value[OPW-1:0];
          3'b010: alu_src1 <= input_value[WIDTH-1:0];
          3'b011: alu_src2 <= input_value[WIDTH-1:0];
          3'b101: begin
            count   <= '0;
            wr_ptr  <= '0;
            timeout <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT && !alu_done) wait_cnt <= wait_cnt + 16'd1;
      if (state == WAIT && alu_done) begin
        cap_result <= alu_result;
        cap_flags  <= alu_flags;
      end
      if (wait_expired) timeout <= 1'b1;
      if (state == COMMIT) begin
        hist[wr_ptr] <= {cap_result, cap_flags};
        wr_ptr       <= wr_ptr + PW'(1);
        if (count != FULL) count <= count + CW'(1);
        last_result  <= cap_result;
        last_flags   <= cap_flags;
      end
    end
  end

  // History slot k reads back from the newest entry, wrapping through the ring.
  logic [5:0]    k;
  logic [PW-1:0] rd_idx;
  logic [7:0]    hex_ch;
  logic          dv_nxt;
  logic [39:0]   dn_nxt;
  logic [31:0]   dval_nxt;

  assign k      = display_number - H_FIRST;
  assign rd_idx = wr_ptr - PW'(1) - k[PW-1:0];
  assign hex_ch = (k < 6'd10) ? (8'h30 + {2'b00, k}) : (8'h37 + {2'b00, k});

  always_comb begin
    dv_nxt   = 1'b1;
    dn_nxt   = '0;
    dval_nxt = '0;
    case (display_number)
      6'd1: begin dn_nxt = 40'h00_0049_4E30; dval_nxt = 32'(alu_src1);    end
      6'd2: begin dn_nxt = 40'h00_0049_4E31; dval_nxt = 32'(alu_src2);    end
      6'd3: begin dn_nxt = 40'h00_0000_4F50; dval_nxt = 32'(alu_op);      end
      6'd4: begin dn_nxt = 40'h00_004F_5031; dval_nxt = 32'(alu_op1);     end
      6'd5: begin dn_nxt = 40'h00_004F_5554; dval_nxt = 32'(last_result); end
      6'd6: begin dn_nxt = 40'h00_464C_4147; dval_nxt = 32'(last_flags);  end
      6'd7: begin dn_nxt = 40'h00_0043_4E54; dval_nxt = 32'(count);       end
      6'd8: begin dn_nxt = 40'h00_5354_4154; dval_nxt = {28'b0, timeout, busy, state}; end
      default: begin
        if (display_number >= H_FIRST && display_number < H_END) begin
          dn_nxt = {24'h0, 8'h48, hex_ch};
          if (k < 6'(count)) dval_nxt = 32'(hist[rd_idx][WIDTH+3:4]);
          else               dv_nxt   = 1'b0;
        end else begin
          dv_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= dv_nxt;
      display_name  <= dn_nxt;
      display_value <= dval_nxt;
    end
  end
endmodule

// File: tb/tb_alu_console.sv
// Randomized bench for alu_console: a transaction-level reference model is compared every cycle
// against a WIDTH=32 and a WIDTH=8 instance driven in lockstep, plus hand-computed literal checks.
module tb_alu_console;
  localparam int D   = 8;
  localparam int TMO = 255;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_COMMIT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [2:0]  input_sel = '0;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic [5:0]  display_number = '0;

  logic [3:0]  alu_op, alu_op1, op_8, op1_8;
  logic [31:0] alu_src1, alu_src2;
  logic [7:0]  src1_8, src2_8;
  logic        alu_start, busy, timeout, display_valid;
  logic        start_8, busy_8, timeout_8, dv_8;
  logic [39:0] display_name, dn_8;
  logic [31:0] display_value, dval_8;

  always #50 clk = ~clk;

  alu_console #(.WIDTH(32), .OPW(4), .HIST_DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .input_valid(input_valid), .input_value(input_value),
    .input_sel(input_sel), .alu_op(alu_op), .alu_op1(alu_op1), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .alu_flags(alu_flags), .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value), .busy(busy), .timeout(timeout));

  alu_console #(.WIDTH(8), .OPW(4), .HIST_DEPTH(D), .TIMEOUT(TMO)) dut8 (
    .clk(clk), .resetn(resetn), .input_valid(input_valid), .input_value(input_value),
    .input_sel(input_sel), .alu_op(op_8), .alu_op1(op1_8), .alu_src1(src1_8),
    .alu_src2(src2_8), .alu_start(start_8), .alu_done(alu_done), .alu_result(alu_result[7:0]),
    .alu_flags(alu_flags), .display_number(display_number), .display_valid(dv_8),
    .display_name(dn_8), .display_value(dval_8), .busy(busy_8), .timeout(timeout_8));

  // Reference model: operation phase, register contents and history as a newest-first queue.
  int          mode = M_IDLE;
  int          waited = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_src1 = '0, m_src2 = '0, m_last = '0, pend_res = '0;
  logic [3:0]  m_op = '0, m_op1 = '0, m_flags = '0, pend_fl = '0;
  logic [31:0] hq[$];
  bit          e_dv = 1'b0, e_dv8 = 1'b0;
  logic [39:0] e_dn = '0, e_dn8 = '0;
  logic [31:0] e_dval = '0, e_dval8 = '0;
  string       hx = "0123456789ABCDEF";

  int n_chk = 0, n_fail = 0, st = 0;
  bit checking = 1'b0, disp_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void mdisp(input int slot, input int w, output bit v,
                                output logic [39:0] nm, output logic [31:0] val);
    logic [31:0] mask;
    logic [7:0]  hc;
    int          kk;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    v = 1'b1; nm = '0; val = '0;
    case (slot)
      1: begin nm = {16'h0, "IN0"};  val = m_src1 & mask; end
      2: begin nm = {16'h0, "IN1"};  val = m_src2 & mask; end
      3: begin nm = {24'h0, "OP"};   val = 32'(m_op); end
      4: begin nm = {16'h0, "OP1"};  val = 32'(m_op1); end
      5: begin nm = {16'h0, "OUT"};  val = m_last & mask; end
      6: begin nm = {8'h0, "FLAG"};  val = 32'(m_flags); end
      7: begin nm = {16'h0, "CNT"};  val = 32'(hq.size()); end
      8: begin nm = {8'h0, "STAT"};  val = {28'b0, m_to, mode != M_IDLE, 2'(mode)}; end
      default: begin
        if (slot >= 9 && slot < 9 + D) begin
          kk = slot - 9;
          hc = hx[kk];
          nm = {24'h0, 8'h48, hc};
          if (kk < hq.size()) val = hq[kk] & mask;
          else v = 1'b0;
        end else begin
          v = 1'b0;
        end
      end
    endcase
  endfunction

  task automatic model_reset();
    mode = M_IDLE; waited = 0; m_to = 1'b0;
    m_src1 = '0; m_src2 = '0; m_last = '0; pend_res = '0;
    m_op = '0; m_op1 = '0; m_flags = '0; pend_fl = '0;
    hq.delete();
    e_dv = 1'b0; e_dv8 = 1'b0; e_dn = '0; e_dn8 = '0; e_dval = '0; e_dval8 = '0;
  endtask

  task automatic model_step();
    mdisp(int'(display_number), 32, e_dv, e_dn, e_dval);
    mdisp(int'(display_number), 8, e_dv8, e_dn8, e_dval8);
    case (mode)
      M_IDLE: if (input_valid) begin
        case (input_sel)
          3'd0: m_op   = input_value[3:0];
          3'd1: m_op1  = input_value[3:0];
          3'd2: m_src1 = input_value;
          3'd3: m_src2 = input_value;
          3'd4: mode   = M_ISSUE;
          3'd5: begin hq.delete(); m_to = 1'b0; end
          default: ;
        endcase
      end
      M_ISSUE: begin mode = M_WAIT; waited = 0; end
      M_WAIT: begin
        if (alu_done) begin
          pend_res = alu_result; pend_fl = alu_flags; mode = M_COMMIT;
        end else begin
          waited++;
          if (waited == TMO) begin m_to = 1'b1; mode = M_IDLE; end
        end
      end
      default: begin
        hq.push_front(pend_res);
        if (hq.size() > D) void'(hq.pop_back());
        m_last = pend_res; m_flags = pend_fl; mode = M_IDLE;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("busy", 64'(busy), 64'(mode != M_IDLE));
      chk("alu_start", 64'(alu_start), 64'(mode == M_ISSUE));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("alu_op", 64'(alu_op), 64'(m_op));
      chk("alu_op1", 64'(alu_op1), 64'(m_op1));
      chk("alu_src1", 64'(alu_src1), 64'(m_src1));
      chk("alu_src2", 64'(alu_src2), 64'(m_src2));
      chk("disp_valid", 64'(display_valid), 64'(e_dv));
      chk("disp_name", 64'(display_name), 64'(e_dn));
      chk("disp_value", 64'(display_value), 64'(e_dval));
      chk("w8_busy", 64'(busy_8), 64'(mode != M_IDLE));
      chk("w8_start", 64'(start_8), 64'(mode == M_ISSUE));
      chk("w8_timeout", 64'(timeout_8), 64'(m_to));
      chk("w8_op", 64'(op_8), 64'(m_op));
      chk("w8_op1", 64'(op1_8), 64'(m_op1));
      chk("w8_src1", 64'(src1_8), 64'(m_src1[7:0]));
      chk("w8_src2", 64'(src2_8), 64'(m_src2[7:0]));
      chk("w8_disp_valid", 64'(dv_8), 64'(e_dv8));
      chk("w8_disp_name", 64'(dn_8), 64'(e_dn8));
      chk("w8_disp_value", 64'(dval_8), 64'(e_dval8));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    input_valid = 1'b0;
    alu_done    = 1'b0;
    if (!disp_hold) display_number = 6'($urandom_range(0, 20));
  endtask

  task automatic enter(input logic [2:0] s, input logic [31:0] v);
    input_valid = 1'b1; input_sel = s; input_value = v;
    tick();
  endtask

  task automatic peek(input logic [5:0] slot);
    disp_hold = 1'b1; display_number = slot;
    tick();
    disp_hold = 1'b0;
  endtask

  // lat: WAIT cycle (1-based) carrying alu_done, -1 for none. noise 1: random traffic while busy
  // plus a stray done in ISSUE; noise 2: src1=0xFFFF and a second exec during WAIT.
  task automatic do_exec(input int lat, input logic [31:0] res, input logic [3:0] flg,
                         input int noise, output int starts);
    starts = 0;
    enter(3'b100, $urandom());
    for (int i = 0; i < 400 && busy; i++) begin
      if (alu_start) starts++;
      if (noise == 1 && i == 0) begin
        alu_done = 1'b1; alu_result = $urandom(); alu_flags = 4'($urandom());
      end
      if (noise == 1 && i > 0 && $urandom_range(0, 2) == 0) begin
        input_valid = 1'b1; input_sel = 3'($urandom_range(0, 5)); input_value = $urandom();
      end
      if (noise == 2 && i == 1) begin input_valid = 1'b1; input_sel = 3'b010; input_value = 32'hFFFF; end
      if (noise == 2 && i == 2) begin input_valid = 1'b1; input_sel = 3'b100; end
      if (i == lat) begin alu_done = 1'b1; alu_result = res; alu_flags = flg; end
      tick();
    end
    chk("exec_returns_idle", 64'(busy), 64'(0));
    chk("start_pulses", 64'(starts), 64'(1));
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    checking = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_start", 64'(alu_start), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_src1", 64'(alu_src1), 64'(0));
    chk("rst_disp_valid", 64'(display_valid), 64'(0));
    tick();

    enter(3'b010, 32'd5);
    enter(3'b011, 32'd7);
    enter(3'b000, 32'd0);
    do_exec(3, 32'd12, 4'd0, 0, st);
    peek(6'd5); chk("a_out", 64'(display_value), 64'(12));
    peek(6'd7); chk("a_cnt", 64'(display_value), 64'(1));
    peek(6'd9); chk("a_h0_valid", 64'(display_valid), 64'(1));
    chk("a_h0_value", 64'(display_value), 64'(12));
    chk("a_h0_name", 64'(display_name), 64'h00_0000_4830);
    peek(6'd10); chk("a_h1_valid", 64'(display_valid), 64'(0));

    enter(3'b101, 32'd0);
    for (int r = 1; r <= 10; r++) do_exec($urandom_range(1, 4), 32'(r), 4'd0, 0, st);
    peek(6'd7);  chk("b_cnt", 64'(display_value), 64'(8));
    peek(6'd9);  chk("b_h0", 64'(display_value), 64'(10));
    peek(6'd16); chk("b_h7", 64'(display_value), 64'(3));

    do_exec(-1, 32'd0, 4'd0, 0, st);
    chk("c_timeout", 64'(timeout), 64'(1));
    chk("c_busy", 64'(busy), 64'(0));
    peek(6'd7); chk("c_cnt_kept", 64'(display_value), 64'(8));
    enter(3'b101, 32'd0);
    chk("c_timeout_cleared", 64'(timeout), 64'(0));
    peek(6'd7); chk("c_cnt_cleared", 64'(display_value), 64'(0));

    enter(3'b010, 32'h1234);
    do_exec(5, 32'h55, 4'h2, 2, st);
    chk("d_src1_kept", 64'(alu_src1), 64'h1234);
    peek(6'd7); chk("d_cnt", 64'(display_value), 64'(1));

    enter(3'b100, 32'd0);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("e_busy", 64'(busy), 64'(0));
    chk("e_start", 64'(alu_start), 64'(0));
    chk("e_src1", 64'(alu_src1), 64'(0));
    chk("e_disp_valid", 64'(display_valid), 64'(0));
    @(posedge clk); #1 resetn = 1'b1;
    peek(6'd7); chk("e_cnt", 64'(display_value), 64'(0));

    enter(3'b010, 32'h1FF);
    do_exec(2, 32'hAB, 4'b1001, 0, st);
    peek(6'd1); chk("f_in0_w8", 64'(dval_8), 64'hFF);
    chk("f_in0_name", 64'(dn_8), 64'h00_0049_4E30);
    chk("f_in0_w32", 64'(display_value), 64'h1FF);
    peek(6'd5); chk("f_out_w8", 64'(dval_8), 64'h0000_00AB);
    peek(6'd6); chk("f_flag_w8", 64'(dval_8), 64'(9));

    for (int it = 0; it < 250; it++) begin
      int c;
      logic [2:0] s;
      c = $urandom_range(0, 99);
      if (c < 40) begin
        s = 3'($urandom_range(0, 6));
        if (s >= 3'd4) s = s + 3'd1;
        enter(s, $urandom());
      end else if (c < 70) begin
        do_exec($urandom_range(1, 6), $urandom(), 4'($urandom()), $urandom_range(0, 1), st);
      end else if (c < 72) begin
        do_exec(-1, 32'd0, 4'd0, 1, st);
      end else if (c < 85) begin
        alu_done = 1'b1; alu_result = $urandom(); alu_flags = 4'($urandom());
        tick();
      end else begin
        tick();
      end
    end

    tick();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(100 * 80000);
    n_fail++;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
